// File: rtl/dreg_pkg.sv
// Shared mode encoding and packed-bus helpers for the dreg_bank register bank.
package dreg_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD  = 2'b00;
    localparam mode_t MODE_LOAD  = 2'b01;
    localparam mode_t MODE_SHIFT = 2'b10;
    localparam mode_t MODE_CLEAR = 2'b11;

    // Low bit index of lane idx in a bus packed as lanes of the given width.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/dreg_cell.sv
// One WIDTH-bit register lane with synchronous reset, load enable and a
// registered flag marking whether the last edge changed the stored value.
module dreg_cell #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             chg_o
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             chg_q, chg_d;

    always_comb begin
        q_d   = q_q;
        chg_d = 1'b0;
        if (en_i) begin
            q_d   = d_i;
            chg_d = (d_i != q_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q   <= RESET_VAL;
            chg_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
        end
    end

    assign q_o   = q_q;
    assign chg_o = chg_q;

endmodule

// File: rtl/dreg_bank.sv
// Multi-channel edge-triggered register bank: per-lane load, shift chain and
// clear, with per-lane change flags and a saturating load-activity counter.
module dreg_bank
    import dreg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CHANNELS  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [CHANNELS*WIDTH-1:0]    d_in,
    input  logic [CHANNELS-1:0]          sel_n_in,
    input  logic [1:0]                   mode_in,
    output logic [CHANNELS*WIDTH-1:0]    y_out,
    output logic [CHANNELS-1:0]          chg_out,
    output logic [CNT_W-1:0]             load_cnt_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mode_t                      mode;
    logic [CHANNELS*WIDTH-1:0]  y_w;
    logic [CHANNELS-1:0]        chg_w;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    assign mode = mode_in;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             en;
        logic [WIDTH-1:0] nxt;
        logic [WIDTH-1:0] shift_src;

        // Lane 0 is fed from the input; higher lanes take their lower neighbour.
        if (i == 0) begin : g_head
            assign shift_src = d_in[WIDTH-1:0];
        end else begin : g_link
            assign shift_src = y_w[slice_lo(i - 1, WIDTH) +: WIDTH];
        end

        always_comb begin
            en  = 1'b0;
            nxt = d_in[slice_lo(i, WIDTH) +: WIDTH];
            case (mode)
                MODE_LOAD: begin
                    en  = ~sel_n_in[i];
                    nxt = d_in[slice_lo(i, WIDTH) +: WIDTH];
                end
                MODE_SHIFT: begin
                    en  = 1'b1;
                    nxt = shift_src;
                end
                MODE_CLEAR: begin
                    en  = 1'b1;
                    nxt = RESET_VAL;
                end
                default: begin
                    en  = 1'b0;
                end
            endcase
        end

        dreg_cell #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .clk_i (clk_in),
            .rst_i (rst_in),
            .en_i  (en),
            .d_i   (nxt),
            .q_o   (y_w[slice_lo(i, WIDTH) +: WIDTH]),
            .chg_o (chg_w[i])
        );
    end

    // Count only LOAD cycles that actually select a lane; hold at the top.
    always_comb begin
        cnt_d = cnt_q;
        if (mode == MODE_CLEAR) begin
            cnt_d = '0;
        end else if ((mode == MODE_LOAD) && !(&sel_n_in) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign y_out        = y_w;
    assign chg_out      = chg_w;
    assign load_cnt_out = cnt_q;

endmodule

// File: doc/dreg_bank.md
# dreg_bank

Parametrised multi-channel edge-triggered data register bank, the clocked successor to the single-bit level-sensitive latch. Holds CHANNELS independent WIDTH-bit values, each with an active-low load select. Bank-wide modes cover hold, selective load, shift-chain and clear. It is the general-purpose storage element for datapath blocks that need registered, per-lane capture with change detection and a load-activity count.

## Interface
- WIDTH, default 8: bits per channel (>= 1).
- CHANNELS, default 4: number of channels (>= 1).
- RESET_VAL, default 0: value loaded into every channel on reset and on CLEAR; WIDTH bits.
- CNT_W, default 8: width of the load-activity counter (>= 1).
- One clock; reset is synchronous and active-high.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- d_in  input  CHANNELS*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
- sel_n_in  input  CHANNELS  per-channel load select, active-low (0 = load).
- mode_in  input  2  bank mode: 00 HOLD, 01 LOAD, 10 SHIFT, 11 CLEAR.
- y_out  output  CHANNELS*WIDTH  registered channel values, same packing as d_in.
- chg_out  output  CHANNELS  per-channel flag: channel value changed on the most recent edge.
- load_cnt_out  output  CNT_W  saturating count of effective LOAD cycles.

## Operation
- Priority: rst_in > mode_in. With rst_in high at an edge, mode_in, sel_n_in and d_in are ignored.
- HOLD (00): every channel keeps its value.
- LOAD (01): channel i takes d_in slice i if sel_n_in[i]==0, otherwise it holds. Channels are independent.
- SHIFT (10): ch0 <= d_in slice 0. Each ch i <= old ch i-1 for i >= 1. The old top channel is discarded. sel_n_in is ignored. With CHANNELS==1, SHIFT behaves as an unconditional load of ch0.
- CLEAR (11): every channel <= RESET_VAL. load_cnt_out <= 0.
- chg_out[i] is 1 after an edge where the new value of ch i differs from its old value, and 0 otherwise. This includes edges where a LOAD or SHIFT writes an identical value (flag stays 0). The comparison covers all WIDTH bits.
- load_cnt_out increments by 1 on an edge where mode_in==LOAD and at least one sel_n_in bit is 0. It saturates at 2^CNT_W-1 and does not wrap. HOLD and SHIFT leave it unchanged.

## Timing
- Reset values (after the first edge with rst_in high): y_out = RESET_VAL in every channel, chg_out = 0, load_cnt_out = 0.
- Latency: 1 cycle. Inputs sampled at edge k appear on y_out, chg_out and load_cnt_out after edge k. No combinational path from any input to any output.
- There is no transparency: d_in changes between edges never reach y_out. This is the key difference from the latch.
- Mode and selects may change every cycle. There is no handshake and no stall.
- Reset asserted mid-sequence (e.g. during a SHIFT run) discards the in-flight update. The next edge after deassertion resumes normal mode decoding.
- Reset does not raise chg_out, even when pre-reset values differed from RESET_VAL.
- Counter at saturation with another LOAD: value stays at 2^CNT_W-1.

## Structure
- Package dreg_pkg holds:
  - MODE_HOLD, MODE_LOAD, MODE_SHIFT, MODE_CLEAR (2-bit constants);
  - the mode typedef;
  - a slice-index helper for the packed buses.
- Sub-module dreg_cell: one WIDTH-bit register with synchronous reset, load enable, load data and a registered change flag. It is instantiated CHANNELS times via generate.
- The top level decodes mode into per-cell enable and data: LOAD picks the d_in slice, SHIFT picks the neighbour cell output, CLEAR picks RESET_VAL. The top level also owns the saturating counter.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4, RESET_VAL=0, CNT_W=2.
- Reset, then HOLD for 3 cycles: y_out=0x00000000, chg_out=0000, load_cnt_out=0 throughout.
- LOAD with d_in=0x44332211 and sel_n_in=1010: after 1 edge, y_out=0x00330011, chg_out=0101, load_cnt_out=1.
- SHIFT for 4 edges with d_in slice 0 = 0xA1, 0xA2, 0xA3, 0xA4: y_out=0xA1A2A3A4. chg_out=1111 on each edge where every lane value changes.
- Five effective LOADs (sel_n_in=0000): load_cnt_out goes 1, 2, 3, 3, 3. A LOAD with sel_n_in=1111 neither increments the counter nor changes y_out.
- Reload the identical value 0x11223344 twice: chg_out=1111 after the first LOAD and 0000 after the second. A following CLEAR gives y_out=0 and load_cnt_out=0.
- Assert rst_in during SHIFT with mode_in held at 10: y_out=0 and chg_out=0 on that edge. Shifting resumes on the edge after rst_in drops.
